// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, FSM state encoding,
// opcode constants used by decode/branch ALU, word-align helper.
package fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_WIDTH = 32;
    localparam int PC_STEP     = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic [XLEN-1:0] align_word(
        input logic [XLEN-1:0] a
    );
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: imem request/response plus decode-side valid/ready.
// master = fetch unit, slave = memory + decode environment.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [XLEN-1:0]        imem_addr;
    logic                   imem_resp_valid;
    logic [INSTR_WIDTH-1:0] imem_resp_data;
    logic                   if_valid;
    logic                   if_ready;
    logic [XLEN-1:0]        if_pc;
    logic [INSTR_WIDTH-1:0] if_instr;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        output if_valid,
        output if_pc,
        output if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output if_ready
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Architectural PC: redirect mux with word alignment, sequential
// increment, and a one-cycle misaligned-target pulse.
// Ports: clock, reset_n, redirect_valid/pc, advance -> pc, misaligned.
module fetch_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     STEP     = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

    logic [XLEN-1:0] pc_d, pc_q;
    logic            misaligned_d, misaligned_q;

    // Redirect beats the sequential step when both occur.
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        if (redirect_valid) begin
            pc_d         = align_word(redirect_pc);
            misaligned_d = |redirect_pc[1:0];
        end else if (advance) begin
            pc_d = pc_q + STEP_W;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc         = pc_q;
    assign misaligned = misaligned_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, one-entry
// output buffer. Ports: clock, reset_n, redirect_valid/pc, misaligned,
// bus (fetch_unit_if.master: imem req/resp + decode handshake).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            misaligned,
    fetch_unit_if.master    bus
);

    fetch_state_e           state_d, state_q;
    logic                   drop_d, drop_q;
    logic [XLEN-1:0]        if_pc_d, if_pc_q;
    logic [INSTR_WIDTH-1:0] if_instr_d, if_instr_q;
    logic                   req_valid_d, req_valid_q;
    logic                   if_valid_d, if_valid_q;
    logic                   advance;
    logic [XLEN-1:0]        pc;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .STEP     (PC_STEP)
    ) u_pc (
        .clock          (clock),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .pc             (pc),
        .misaligned     (misaligned)
    );

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        advance    = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                    // Old address already issued: its data is stale.
                    drop_d  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (redirect_valid) begin
                        state_d = S_REQ;
                    end else begin
                        if_pc_d    = pc;
                        if_instr_d = bus.imem_resp_data;
                        state_d    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                advance = bus.if_ready;
                if (redirect_valid || bus.if_ready) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_valid_d = (state_d == S_REQ);
        if_valid_d  = (state_d == S_HOLD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            drop_q      <= 1'b0;
            if_pc_q     <= '0;
            if_instr_q  <= '0;
            req_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            req_valid_q <= req_valid_d;
            if_valid_q  <= if_valid_d;
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_addr      = pc;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_instr       = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: imem responder with set latency,
// handshake monitor, hand-computed expectations.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        misaligned;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misaligned     (misaligned),
        .bus            (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int lat = 1;
    int cyc = 0;

    logic [31:0] cons_pc [16];
    logic [31:0] cons_in [16];
    int          cons_cyc[16];
    int          ncons = 0;
    logic [31:0] req_a   [16];
    int          nreq = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // imem responder: one response lat cycles after acceptance
    initial begin : mem_model
        logic        acc;
        logic [31:0] acc_a;
        logic [31:0] paddr;
        logic        pend;
        int          cnt;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        pend  = 1'b0;
        paddr = 32'h0;
        cnt   = 0;
        forever begin
            @(negedge clock);
            acc   = bus.imem_req_valid && bus.imem_req_ready;
            acc_a = bus.imem_addr;
            @(posedge clock);
            #1;
            if (!reset_n) begin
                pend = 1'b0;
                bus.imem_resp_valid = 1'b0;
            end else begin
                if (bus.imem_resp_valid) begin
                    bus.imem_resp_valid = 1'b0;
                    pend = 1'b0;
                end
                if (acc) begin
                    pend  = 1'b1;
                    cnt   = lat;
                    paddr = acc_a;
                end
                if (pend && !bus.imem_resp_valid) begin
                    cnt--;
                    if (cnt <= 0) begin
                        bus.imem_resp_valid = 1'b1;
                        bus.imem_resp_data  = instr_of(paddr);
                    end
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clock);
            cyc++;
            if (reset_n) begin
                assert (bus.imem_addr[1:0] == 2'b00);
                if (bus.if_valid && bus.if_ready && ncons < 16) begin
                    cons_pc[ncons]  = bus.if_pc;
                    cons_in[ncons]  = bus.if_instr;
                    cons_cyc[ncons] = cyc;
                    ncons++;
                end
                if (bus.imem_req_valid && bus.imem_req_ready
                    && nreq < 16) begin
                    req_a[nreq] = bus.imem_addr;
                    nreq++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        repeat (3) step();
        ncons = 0;
        nreq  = 0;
        reset_n = 1'b1;
    endtask

    task automatic run_cons(input int n, input int budget);
        int k;
        k = 0;
        while (ncons < n && k < budget) begin
            step();
            k++;
        end
        chk("cons_count", 32'(ncons), 32'(n));
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin : main
        int k;
        int good;
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;

        // reset state
        reset_n = 1'b0;
        step();
        step();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_if_instr", bus.if_instr, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        ncons = 0;
        nreq  = 0;
        reset_n = 1'b1;

        // sequential fetch, 3 cycles per instruction
        run_cons(3, 40);
        for (int i = 0; i < 3; i++) begin
            chk("t1_pc", cons_pc[i], 32'(i * 4));
            chk("t1_instr", cons_in[i], instr_of(32'(i * 4)));
            chk("t1_addr", req_a[i], 32'(i * 4));
        end
        chk("t1_rate", 32'(cons_cyc[2] - cons_cyc[1]), 32'd3);

        // decode stall in HOLD
        do_reset();
        run_cons(1, 20);
        bus.if_ready = 1'b0;
        k = 0;
        while (!bus.if_valid && k < 20) begin
            step();
            k++;
        end
        chk("t2_hold_pc", bus.if_pc, 32'h4);
        good = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.if_valid && bus.if_pc == 32'h4
                && bus.if_instr == instr_of(32'h4)
                && !bus.imem_req_valid)
                good++;
            step();
        end
        chk("t2_stable", 32'(good), 32'd5);
        chk("t2_nreq", 32'(nreq), 32'd2);
        bus.if_ready = 1'b1;
        run_cons(2, 20);
        chk("t2_pc", cons_pc[1], 32'h4);
        chk("t2_instr", cons_in[1], instr_of(32'h4));

        // redirect during WAIT, response dropped
        do_reset();
        lat = 2;
        k = 0;
        while (!(bus.imem_req_valid && bus.imem_addr == 32'h8)
               && k < 40) begin
            step();
            k++;
        end
        step();
        redirect(32'h100);
        run_cons(3, 60);
        chk("t3_pc1", cons_pc[1], 32'h4);
        chk("t3_pc2", cons_pc[2], 32'h100);
        chk("t3_instr2", cons_in[2], instr_of(32'h100));
        chk("t3_addr2", req_a[2], 32'h8);
        chk("t3_addr3", req_a[3], 32'h100);

        // redirect together with HOLD handshake
        do_reset();
        lat = 1;
        k = 0;
        while (!(bus.if_valid && bus.if_pc == 32'h10) && k < 60) begin
            step();
            k++;
        end
        redirect(32'h200);
        run_cons(6, 40);
        chk("t4_pc4", cons_pc[4], 32'h10);
        chk("t4_pc5", cons_pc[5], 32'h200);
        chk("t4_addr5", req_a[5], 32'h200);

        // misaligned redirect while REQ is stalled
        do_reset();
        bus.imem_req_ready = 1'b0;
        k = 0;
        while (!bus.imem_req_valid && k < 10) begin
            step();
            k++;
        end
        redirect(32'h102);
        chk("t5_mis_hi", 32'(misaligned), 32'h1);
        chk("t5_addr", bus.imem_addr, 32'h100);
        chk("t5_req", 32'(bus.imem_req_valid), 32'h1);
        step();
        chk("t5_mis_lo", 32'(misaligned), 32'h0);
        bus.imem_req_ready = 1'b1;
        run_cons(1, 20);
        chk("t5_pc", cons_pc[0], 32'h100);
        chk("t5_addr0", req_a[0], 32'h100);

        // wrap at top of address space, then async reset in WAIT
        do_reset();
        redirect(32'hFFFF_FFFC);
        run_cons(3, 40);
        chk("t6_addr0", req_a[0], 32'hFFFF_FFFC);
        chk("t6_addr1", req_a[1], 32'h0);
        chk("t6_pc0", cons_pc[0], 32'hFFFF_FFFC);
        chk("t6_pc1", cons_pc[1], 32'h0);
        lat = 3;
        k = 0;
        while (!(bus.imem_req_valid && bus.imem_addr == 32'h8)
               && k < 40) begin
            step();
            k++;
        end
        step();
        chk("t6_pre_pc", bus.if_pc, 32'h4);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_ar_req", 32'(bus.imem_req_valid), 32'h0);
        chk("t6_ar_valid", 32'(bus.if_valid), 32'h0);
        chk("t6_ar_pc", bus.if_pc, 32'h0);
        chk("t6_ar_instr", bus.if_instr, 32'h0);
        chk("t6_ar_addr", bus.imem_addr, 32'h0);
        step();
        step();
        ncons = 0;
        nreq  = 0;
        lat = 1;
        reset_n = 1'b1;
        run_cons(2, 30);
        chk("t6_re_addr", req_a[0], 32'h0);
        chk("t6_re_pc0", cons_pc[0], 32'h0);
        chk("t6_re_pc1", cons_pc[1], 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
